// File: rtl/ldm_stm_seq_if.sv
// ldm_stm_seq_if
// Bus bundle between the EX/MEM block-transfer sequencer and its environment.
// Ports (signals carried):
//   i_start, i_reg_list[15:0], i_base[31:0], i_rn_code[3:0], i_p, i_u, i_w, i_l
//       decoded LDM/STM instruction fields, driven by the pipeline
//   i_mem_rdy            memory accepts the current transfer
//   o_mem_vld, o_mem_addr[31:0], o_mem_we, o_xfer_reg[3:0]
//       memory transfer request
//   o_ldm_hold           pipeline hold, to the hazard controller
//   o_wb_base_vld, o_wb_base_data[31:0]
//       base register write-back
//   o_done               one-cycle end-of-instruction pulse
// Modports: slave = sequencer, master = pipeline/memory side.
interface ldm_stm_seq_if;
    logic        i_start;
    logic [15:0] i_reg_list;
    logic [31:0] i_base;
    logic [3:0]  i_rn_code;
    logic        i_p;
    logic        i_u;
    logic        i_w;
    logic        i_l;
    logic        i_mem_rdy;
    logic        o_mem_vld;
    logic [31:0] o_mem_addr;
    logic        o_mem_we;
    logic [3:0]  o_xfer_reg;
    logic        o_ldm_hold;
    logic        o_wb_base_vld;
    logic [31:0] o_wb_base_data;
    logic        o_done;

    modport master (
        output i_start, i_reg_list, i_base, i_rn_code, i_p, i_u, i_w, i_l, i_mem_rdy,
        input  o_mem_vld, o_mem_addr, o_mem_we, o_xfer_reg, o_ldm_hold,
        input  o_wb_base_vld, o_wb_base_data, o_done
    );

    modport slave (
        input  i_start, i_reg_list, i_base, i_rn_code, i_p, i_u, i_w, i_l, i_mem_rdy,
        output o_mem_vld, o_mem_addr, o_mem_we, o_xfer_reg, o_ldm_hold,
        output o_wb_base_vld, o_wb_base_data, o_done
    );
endinterface

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq
// LDM/STM multiple-transfer sequencer. Issues one word transfer per accepted
// memory handshake in ascending register order, holds the pipeline until the
// last transfer is accepted and produces the base register write-back.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   ldm_stm_seq_if.slave: instruction fields, memory handshake,
//            pipeline hold, base write-back and done pulse
module ldm_stm_seq (
    input  logic          i_clk,
    input  logic          i_rst_n,
    ldm_stm_seq_if.slave  io_bus
);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e      r_state, w_state_nxt;
    logic [15:0] r_mask, w_mask_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_we, w_we_nxt;
    logic        r_wb_en, w_wb_en_nxt;
    logic [31:0] r_wb_data, w_wb_data_nxt;

    logic [4:0]  w_count;
    logic [31:0] w_base_al;
    logic [31:0] w_span;
    logic [31:0] w_start_addr;
    logic [31:0] w_wb_value;
    logic        w_wb_start;
    logic [3:0]  w_idx;
    logic        w_busy;
    logic        w_req;
    logic        w_last;
    logic        w_accept;
    logic        w_done;

    // Number of registers in the list, 0..16
    always_comb begin
        w_count = '0;
        for (int i = 0; i < 16; i++) begin
            w_count = w_count + {4'd0, io_bus.i_reg_list[i]};
        end
    end

    assign w_base_al = {io_bus.i_base[31:2], 2'b00};
    assign w_span    = {25'd0, w_count, 2'b00};

    always_comb begin
        w_start_addr = w_base_al;
        unique case ({io_bus.i_p, io_bus.i_u})
            2'b01:   w_start_addr = w_base_al;                    // IA
            2'b11:   w_start_addr = w_base_al + 32'd4;            // IB
            2'b00:   w_start_addr = w_base_al - w_span + 32'd4;   // DA
            2'b10:   w_start_addr = w_base_al - w_span;           // DB
            default: w_start_addr = w_base_al;
        endcase
    end

    assign w_wb_value = io_bus.i_u ? (io_bus.i_base + w_span) : (io_bus.i_base - w_span);

    // A load that includes the base register keeps the loaded value; empty list never writes back
    assign w_wb_start = io_bus.i_w && (io_bus.i_reg_list != 16'd0) &&
                        !(io_bus.i_l && io_bus.i_reg_list[io_bus.i_rn_code]);

    // Lowest set bit of the remaining mask
    always_comb begin
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_busy   = (r_state == StXfer);
    assign w_req    = w_busy && (r_mask != 16'd0);
    assign w_last   = ((r_mask & (r_mask - 16'd1)) == 16'd0);
    assign w_accept = w_req && io_bus.i_mem_rdy;
    assign w_done   = w_busy && ((r_mask == 16'd0) || (w_accept && w_last));

    always_comb begin
        w_state_nxt   = r_state;
        w_mask_nxt    = r_mask;
        w_addr_nxt    = r_addr;
        w_we_nxt      = r_we;
        w_wb_en_nxt   = r_wb_en;
        w_wb_data_nxt = r_wb_data;
        unique case (r_state)
            StIdle: begin
                if (io_bus.i_start) begin
                    w_state_nxt   = StXfer;
                    w_mask_nxt    = io_bus.i_reg_list;
                    w_addr_nxt    = w_start_addr;
                    w_we_nxt      = !io_bus.i_l;
                    w_wb_en_nxt   = w_wb_start;
                    w_wb_data_nxt = w_wb_value;
                end
            end
            StXfer: begin
                if (w_accept) begin
                    // Clears the lowest set bit
                    w_mask_nxt = r_mask & (r_mask - 16'd1);
                    w_addr_nxt = r_addr + 32'd4;
                end
                if (w_done) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_mask    <= '0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_addr    <= w_addr_nxt;
            r_we      <= w_we_nxt;
            r_wb_en   <= w_wb_en_nxt;
            r_wb_data <= w_wb_data_nxt;
        end
    end

    // Request fields read as zero whenever no transfer is being requested
    assign io_bus.o_mem_vld      = w_req;
    assign io_bus.o_mem_addr     = w_req ? r_addr : 32'd0;
    assign io_bus.o_mem_we       = w_req && r_we;
    assign io_bus.o_xfer_reg     = w_req ? w_idx : 4'd0;
    assign io_bus.o_ldm_hold     = w_busy ? !w_done : io_bus.i_start;
    assign io_bus.o_done         = w_done;
    assign io_bus.o_wb_base_vld  = w_done && r_wb_en;
    assign io_bus.o_wb_base_data = r_wb_data;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq
// Directed, table-driven bench for ldm_stm_seq. Each vector is one clock
// cycle: inputs applied #1 after the rising edge, outputs sampled on the
// falling edge.
module tb_ldm_stm_seq;

    typedef struct packed {
        logic [15:0] list;
        logic [31:0] base;
        logic [3:0]  rn;
        logic        p;
        logic        u;
        logic        w;
        logic        l;
    } instr_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  xreg;
        logic        hold;
        logic        wbv;
        logic [31:0] wbd;
        logic        done;
    } outs_t;

    typedef struct {
        int     ins;
        logic   start;
        logic   rdy;
        outs_t  exp;
        string  name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ldm_stm_seq_if bus ();

    ldm_stm_seq dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    instr_t ins_tab [9];
    vec_t   vecs [$];

    function automatic outs_t o(logic vld, logic [31:0] addr, logic we, logic [3:0] xr,
                                logic hold, logic wbv, logic [31:0] wbd, logic done);
        outs_t r;
        r.vld = vld; r.addr = addr; r.we = we; r.xreg = xr;
        r.hold = hold; r.wbv = wbv; r.wbd = wbd; r.done = done;
        return r;
    endfunction

    function automatic vec_t mk(int ins, logic st, logic rdy, outs_t exp, string name);
        vec_t v;
        v.ins = ins; v.start = st; v.rdy = rdy; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic drive(instr_t in, logic st, logic rdy);
        bus.i_start    = st;
        bus.i_reg_list = in.list;
        bus.i_base     = in.base;
        bus.i_rn_code  = in.rn;
        bus.i_p        = in.p;
        bus.i_u        = in.u;
        bus.i_w        = in.w;
        bus.i_l        = in.l;
        bus.i_mem_rdy  = rdy;
    endtask

    // full=1 also compares o_wb_base_data when no write-back is expected
    task automatic check(string name, outs_t exp, bit full);
        outs_t act;
        act = o(bus.o_mem_vld, bus.o_mem_addr, bus.o_mem_we, bus.o_xfer_reg,
                bus.o_ldm_hold, bus.o_wb_base_vld, bus.o_wb_base_data, bus.o_done);
        if (!full && !exp.wbv) act.wbd = exp.wbd;
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got vld=%b addr=%h we=%b reg=%0d hold=%b wbv=%b wbd=%h done=%b, want vld=%b addr=%h we=%b reg=%0d hold=%b wbv=%b wbd=%h done=%b",
                     name, act.vld, act.addr, act.we, act.xreg, act.hold, act.wbv, act.wbd,
                     act.done, exp.vld, exp.addr, exp.we, exp.xreg, exp.hold, exp.wbv,
                     exp.wbd, exp.done);
        end
    endtask

    task automatic step(int ins, logic st, logic rdy, outs_t exp, string name);
        @(posedge clk);
        #1;
        drive(ins_tab[ins], st, rdy);
        @(negedge clk);
        check(name, exp, 1'b0);
    endtask

    outs_t zero;
    outs_t hold1;

    initial begin
        zero  = o(1'b0, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0, 1'b0);
        hold1 = o(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0);

        //                 list      base          rn     p     u     w     l
        ins_tab[0] = '{16'h0013, 32'h0000_1000, 4'd13, 1'b0, 1'b1, 1'b1, 1'b0}; // STM IA
        ins_tab[1] = '{16'h8001, 32'h0000_2000, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1}; // LDM DB
        ins_tab[2] = '{16'h0008, 32'h0000_3000, 4'd3,  1'b0, 1'b1, 1'b1, 1'b1}; // LDM Rn in list
        ins_tab[3] = '{16'h0000, 32'h0000_4000, 4'd1,  1'b0, 1'b1, 1'b1, 1'b0}; // empty list
        ins_tab[4] = '{16'h00C0, 32'h0000_5000, 4'd2,  1'b1, 1'b1, 1'b1, 1'b0}; // STM IB
        ins_tab[5] = '{16'h0005, 32'h0000_6000, 4'd9,  1'b0, 1'b0, 1'b0, 1'b1}; // LDM DA, W=0
        ins_tab[6] = '{16'h0003, 32'hFFFF_FFFC, 4'd5,  1'b0, 1'b1, 1'b1, 1'b0}; // wrap
        ins_tab[7] = '{16'h0003, 32'h0000_7000, 4'd4,  1'b0, 1'b1, 1'b0, 1'b0}; // wait states
        ins_tab[8] = '{16'h000F, 32'h0000_8000, 4'd12, 1'b0, 1'b1, 1'b1, 1'b0}; // reset abort

        // STM IA, regs 0,1,4
        vecs.push_back(mk(0, 1, 1, hold1, "ia_c0"));
        vecs.push_back(mk(0, 0, 1, o(1, 32'h1000, 1, 4'd0, 1, 0, 0, 0), "ia_c1"));
        vecs.push_back(mk(0, 0, 1, o(1, 32'h1004, 1, 4'd1, 1, 0, 0, 0), "ia_c2"));
        vecs.push_back(mk(0, 0, 1, o(1, 32'h1008, 1, 4'd4, 0, 1, 32'h100C, 1), "ia_c3"));
        vecs.push_back(mk(0, 0, 1, zero, "ia_idle"));
        // LDM DB, r0 and r15
        vecs.push_back(mk(1, 1, 1, hold1, "db_c0"));
        vecs.push_back(mk(1, 0, 1, o(1, 32'h1FF8, 0, 4'd0, 1, 0, 0, 0), "db_c1"));
        vecs.push_back(mk(1, 0, 1, o(1, 32'h1FFC, 0, 4'd15, 0, 1, 32'h1FF8, 1), "db_c2"));
        // Back-to-back start right after done; base in list suppresses write-back
        vecs.push_back(mk(2, 1, 1, hold1, "rn_c0"));
        vecs.push_back(mk(2, 0, 1, o(1, 32'h3000, 0, 4'd3, 0, 0, 0, 1), "rn_c1"));
        vecs.push_back(mk(2, 0, 1, zero, "rn_idle"));
        // Empty list
        vecs.push_back(mk(3, 1, 1, hold1, "empty_c0"));
        vecs.push_back(mk(3, 0, 1, o(0, 32'h0, 0, 4'd0, 0, 0, 0, 1), "empty_c1"));
        vecs.push_back(mk(3, 0, 1, zero, "empty_idle"));
        // STM IB; start asserted mid-sequence is ignored
        vecs.push_back(mk(4, 1, 1, hold1, "ib_c0"));
        vecs.push_back(mk(4, 0, 1, o(1, 32'h5004, 1, 4'd6, 1, 0, 0, 0), "ib_c1"));
        vecs.push_back(mk(4, 1, 1, o(1, 32'h5008, 1, 4'd7, 0, 1, 32'h5008, 1), "ib_c2"));
        vecs.push_back(mk(4, 0, 1, zero, "ib_idle"));
        // LDM DA without write-back
        vecs.push_back(mk(5, 1, 1, hold1, "da_c0"));
        vecs.push_back(mk(5, 0, 1, o(1, 32'h5FFC, 0, 4'd0, 1, 0, 0, 0), "da_c1"));
        vecs.push_back(mk(5, 0, 1, o(1, 32'h6000, 0, 4'd2, 0, 0, 0, 1), "da_c2"));
        vecs.push_back(mk(5, 0, 1, zero, "da_idle"));
        // Address wrap
        vecs.push_back(mk(6, 1, 1, hold1, "wrap_c0"));
        vecs.push_back(mk(6, 0, 1, o(1, 32'hFFFF_FFFC, 1, 4'd0, 1, 0, 0, 0), "wrap_c1"));
        vecs.push_back(mk(6, 0, 1, o(1, 32'h0000_0000, 1, 4'd1, 0, 1, 32'h4, 1), "wrap_c2"));
        vecs.push_back(mk(6, 0, 1, zero, "wrap_idle"));

        // Reset state
        drive(ins_tab[0], 1'b0, 1'b1);
        @(negedge clk);
        check("reset", zero, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].ins, vecs[i].start, vecs[i].rdy, vecs[i].exp, vecs[i].name);
        end

        // Two wait cycles on the first transfer
        step(7, 1, 1, hold1, "wait_c0");
        step(7, 0, 0, o(1, 32'h7000, 1, 4'd0, 1, 0, 0, 0), "wait_c1");
        step(7, 0, 0, o(1, 32'h7000, 1, 4'd0, 1, 0, 0, 0), "wait_c2");
        step(7, 0, 1, o(1, 32'h7000, 1, 4'd0, 1, 0, 0, 0), "wait_c3");
        step(7, 0, 1, o(1, 32'h7004, 1, 4'd1, 0, 0, 0, 1), "wait_c4");
        step(7, 0, 1, zero, "wait_idle");

        // Reset in the middle of a 4-register STM
        step(8, 1, 1, hold1, "abort_c0");
        step(8, 0, 1, o(1, 32'h8000, 1, 4'd0, 1, 0, 0, 0), "abort_c1");
        step(8, 0, 1, o(1, 32'h8004, 1, 4'd1, 1, 0, 0, 0), "abort_c2");
        @(posedge clk);
        #1;
        drive(ins_tab[8], 1'b0, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_rst", zero, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_release", zero, 1'b1);
        step(8, 1, 1, hold1, "restart_c0");
        step(8, 0, 1, o(1, 32'h8000, 1, 4'd0, 1, 0, 0, 0), "restart_c1");
        step(8, 0, 1, o(1, 32'h8004, 1, 4'd1, 1, 0, 0, 0), "restart_c2");
        step(8, 0, 1, o(1, 32'h8008, 1, 4'd2, 1, 0, 0, 0), "restart_c3");
        step(8, 0, 1, o(1, 32'h800C, 1, 4'd3, 0, 1, 32'h8010, 1), "restart_c4");
        step(8, 0, 1, zero, "restart_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Multiple-transfer sequencer for LDM/STM in the EX/MEM stage. Given a decoded block-transfer instruction, it issues one word transfer per accepted memory handshake in ascending register order. It drives the pipeline hold that the hazard controller consumes as `i_ldm_hold`, so the pipeline stays frozen until the last transfer completes. It also produces the base-register write-back.

## Interface
Parameters: none.
- `i_clk` in 1 — clock, rising edge.
- `i_rst_n` in 1 — asynchronous, active-low reset.
- `i_start` in 1 — decoded LDM/STM present in EX; sampled only in IDLE.
- `i_reg_list` in 16 — register list; bit n selects Rn.
- `i_base` in 32 — value of the base register Rn.
- `i_rn_code` in 4 — base register number.
- `i_p`, `i_u`, `i_w`, `i_l` in 1 each — pre-index, up, write-back, load.
- `i_mem_rdy` in 1 — memory accepts the current transfer.
- `o_mem_vld` out 1 — transfer request valid.
- `o_mem_addr` out 32 — word address, bits [1:0] always 0.
- `o_mem_we` out 1 — 1 for STM, 0 for LDM.
- `o_xfer_reg` out 4 — register loaded or stored in this transfer.
- `o_ldm_hold` out 1 — pipeline hold, to the hazard controller.
- `o_wb_base_vld` out 1 — base write-back strobe.
- `o_wb_base_data` out 32 — new base value.
- `o_done` out 1 — one-cycle pulse when the instruction finishes.

## Operation
- States: IDLE, XFER.
- In IDLE with `i_start`=1, latch the following and go to XFER:
  - `i_reg_list` as the remaining mask;
  - the start address;
  - `i_l`, `i_rn_code`, `i_w`, `i_u`;
  - the count N = popcount(`i_reg_list`), a 5-bit value 0..16.
- Start address, all arithmetic mod 2^32, with `i_base[1:0]` forced to 0:
  - IA (P=0, U=1): base.
  - IB (P=1, U=1): base+4.
  - DA (P=0, U=0): base−4N+4.
  - DB (P=1, U=0): base−4N.
- Write-back value: base+4N if U=1, base−4N if U=0.
- In XFER:
  - `o_mem_vld`=1.
  - `o_xfer_reg` = lowest set bit of the remaining mask.
  - `o_mem_addr` = current address.
  - On `i_mem_rdy`: clear that mask bit and add 4 to the address.
  - When the cleared bit was the last one set, return to IDLE and pulse `o_done`.
- With `i_mem_rdy`=0, all XFER outputs hold stable (no change to address or register).
- Base write-back: `o_wb_base_vld`=1 in the same cycle as `o_done`, only when W=1.
  - Suppressed when L=1 and bit `i_rn_code` of the latched list is set; the loaded value wins.
- Empty list (N=0): enter XFER, issue no transfer, pulse `o_done` on the next cycle, no write-back.
- `i_start` while in XFER is ignored.
- `o_ldm_hold` is combinational:
  - IDLE: equals `i_start`.
  - XFER: 1 except in the cycle the final transfer is accepted, or in the single XFER cycle of an empty list.

## Timing
- Reset: asynchronous; state goes to IDLE, mask to 0, all outputs to 0 (`o_mem_addr`=0, `o_wb_base_data`=0).
- Reset during XFER aborts the instruction immediately; no `o_done`, no write-back.
- Cycle 0: `i_start`; `o_ldm_hold`=1; no memory request yet.
- Cycle 1: first request, with all outputs registered except `o_ldm_hold`.
- With zero wait states, N transfers occupy cycles 1..N.
  - `o_done` and `o_wb_base_vld` are asserted in cycle N together with the final accept.
  - `o_ldm_hold` is low in cycle N.
- Each wait cycle (`i_mem_rdy`=0) extends the sequence by one cycle, with hold kept high.
- A new `i_start` can be accepted in the cycle after `o_done`.
- Address wrap: 0xFFFFFFFC + 4 = 0x00000000, with no error.

## Test plan
- STM IA: base 0x1000, list 0x0013, W=1, rdy always 1.
  - Required: regs 0,1,4 at 0x1000, 0x1004, 0x1008 in cycles 1–3.
  - Hold is 1 in cycles 0–2; write-back 0x100C with `o_done` in cycle 3.
- LDM DB: base 0x2000, list 0x8001, W=1.
  - Required: addresses 0x1FF8 (r0) and 0x1FFC (r15).
  - Write-back 0x1FF8.
- LDM IA with Rn in list: Rn=3, list 0x0008, W=1.
  - Required: one transfer of r3 at base and `o_done`, with `o_wb_base_vld`=0.
- Wait states: list 0x0003 with `i_mem_rdy` low for 2 cycles on the first transfer.
  - Required: `o_mem_addr` and `o_xfer_reg` stable while waiting, hold high.
  - `o_done` in cycle 4.
- Empty list with W=1.
  - Required: no `o_mem_vld`; `o_done` in cycle 1; no write-back; hold 1 only in cycle 0.
- `i_rst_n` asserted in the middle of a 4-register STM.
  - Required: all outputs 0 immediately; the next `i_start` restarts cleanly from the first register.
